sw_pe: RTL and testbench

//  One Smith-Waterman systolic processing element (linear gap). Holds one query base, scores streamed

---
 rtl/sw_pkg.sv | 22 ++
 rtl/sw_max4.sv | 34 +++
 rtl/sw_pe.sv | 104 ++++++++++
 tb/tb_sw_pe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared encodings for the Smith-Waterman systolic array: base codes,
// traceback direction codes and default datapath widths.
package sw_pkg;

  localparam int SCORE_W_DEF = 12;
  localparam int COL_W_DEF   = 8;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  typedef enum logic [1:0] {
    T_STOP = 2'd0,
    T_DIAG = 2'd1,
    T_UP   = 2'd2,
    T_LEFT = 2'd3
  } dir_t;

endpackage

// File: rtl/sw_max4.sv
// Combinational max of {0, diag, up, left}; earlier candidates win ties, so a
// zero result always reports STOP and DIAG beats UP beats LEFT.
module sw_max4
  import sw_pkg::*;
#(
  parameter int W = 14
) (
  input  logic signed [W-1:0] diag,
  input  logic signed [W-1:0] up,
  input  logic signed [W-1:0] left,
  output logic signed [W-1:0] best,
  output dir_t                dir
);

  logic signed [W-1:0] cand [4];

  assign cand[0] = '0;
  assign cand[1] = diag;
  assign cand[2] = up;
  assign cand[3] = left;

  // Candidate index equals its direction code; strict compare keeps the earlier one on ties.
  always_comb begin
    best = cand[0];
    dir  = T_STOP;
    for (int i = 1; i < 4; i++) begin
      if (cand[i] > best) begin
        best = cand[i];
        dir  = dir_t'(i[1:0]);
      end
    end
  end

endmodule

// File: rtl/sw_pe.sv
// One linear-gap Smith-Waterman processing element: scores a streamed reference
// base against its stored query base and tracks the best local score/column.
module sw_pe
  import sw_pkg::*;
#(
  parameter int SCORE_W  = SCORE_W_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               q_load,
  input  logic [1:0]         q_in,
  input  logic               valid_in,
  input  logic               first_in,
  input  logic [1:0]         s_in,
  input  logic [SCORE_W-1:0] h_in,
  output logic               valid_out,
  output logic               first_out,
  output logic [1:0]         s_out,
  output logic [SCORE_W-1:0] h_out,
  output logic               t_valid,
  output logic [1:0]         t_out,
  output logic [SCORE_W-1:0] max_score,
  output logic [COL_W-1:0]   max_col
);

  localparam int EW = SCORE_W + 2;
  localparam logic signed [EW-1:0] MATCH_S = EW'(MATCH);
  localparam logic signed [EW-1:0] MISM_S  = EW'(-MISMATCH);
  localparam logic signed [EW-1:0] GAP_S   = EW'(GAP);

  logic [1:0]          q_reg;
  logic [SCORE_W-1:0]  h_diag_reg;
  logic [SCORE_W-1:0]  h_left_reg;
  logic [COL_W-1:0]    col_reg;

  logic signed [EW-1:0] hd_ext, hl_ext, hu_ext;
  logic signed [EW-1:0] diag_s, up_s, left_s, best_s;
  dir_t                 dir;
  logic [SCORE_W-1:0]   h_next;
  logic [COL_W-1:0]     col_next;

  // A first beat starts a new matrix column 0, so the left/diag neighbours are the zero border.
  always_comb begin
    hd_ext   = first_in ? '0 : {2'b00, h_diag_reg};
    hl_ext   = first_in ? '0 : {2'b00, h_left_reg};
    hu_ext   = {2'b00, h_in};
    diag_s   = hd_ext + ((s_in == q_reg) ? MATCH_S : MISM_S);
    up_s     = hu_ext - GAP_S;
    left_s   = hl_ext - GAP_S;
    col_next = first_in ? '0 : col_reg + COL_W'(1);
  end

  sw_max4 #(.W(EW)) u_max4 (
    .diag (diag_s),
    .up   (up_s),
    .left (left_s),
    .best (best_s),
    .dir  (dir)
  );

  // best_s is never negative, so any set guard bit means overflow.
  assign h_next = (best_s[EW-1:SCORE_W] != '0) ? {SCORE_W{1'b1}} : best_s[SCORE_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg      <= '0;
      h_diag_reg <= '0;
      h_left_reg <= '0;
      col_reg    <= '0;
      valid_out  <= 1'b0;
      first_out  <= 1'b0;
      s_out      <= '0;
      h_out      <= '0;
      t_valid    <= 1'b0;
      t_out      <= '0;
      max_score  <= '0;
      max_col    <= '0;
    end else begin
      if (q_load) begin
        q_reg <= q_in;
      end
      valid_out <= valid_in;
      t_valid   <= valid_in;
      if (valid_in) begin
        first_out  <= first_in;
        s_out      <= s_in;
        h_out      <= h_next;
        t_out      <= dir;
        h_diag_reg <= h_in;
        h_left_reg <= h_next;
        col_reg    <= col_next;
        if (first_in || (h_next > max_score)) begin
          max_score <= h_next;
          max_col   <= col_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_pe.sv
// Table-driven scoreboard bench for sw_pe: a 12-bit instance for the main
// scoring cases and a 4-bit instance for saturation.
module tb_sw_pe;
  import sw_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic q_load, valid_in, first_in;
  logic [1:0] q_in, s_in;
  logic [11:0] h_in;

  logic        vo, fo, tv;
  logic [1:0]  so, to;
  logic [11:0] ho, ms;
  logic [7:0]  mc;

  logic        vo4, fo4, tv4;
  logic [1:0]  so4, to4;
  logic [3:0]  ho4, ms4;
  logic [7:0]  mc4;

  always #5 clk = ~clk;

  sw_pe dut (
    .clk(clk), .reset(reset), .q_load(q_load), .q_in(q_in),
    .valid_in(valid_in), .first_in(first_in), .s_in(s_in), .h_in(h_in),
    .valid_out(vo), .first_out(fo), .s_out(so), .h_out(ho),
    .t_valid(tv), .t_out(to), .max_score(ms), .max_col(mc)
  );

  sw_pe #(.SCORE_W(4)) dut_sat (
    .clk(clk), .reset(reset), .q_load(q_load), .q_in(q_in),
    .valid_in(valid_in), .first_in(first_in), .s_in(s_in), .h_in(h_in[3:0]),
    .valid_out(vo4), .first_out(fo4), .s_out(so4), .h_out(ho4),
    .t_valid(tv4), .t_out(to4), .max_score(ms4), .max_col(mc4)
  );

  typedef struct {
    logic        ld;
    logic [1:0]  q;
    logic        vld;
    logic        first;
    logic [1:0]  s;
    logic [11:0] h;
    logic        sat;
    logic [11:0] eh;
    logic [1:0]  et;
    logic [11:0] em;
    logic [7:0]  ec;
  } vec_t;

  typedef struct {
    logic        sat;
    logic        first;
    logic [1:0]  s;
    logic [11:0] eh;
    logic [1:0]  et;
    logic [11:0] em;
    logic [7:0]  ec;
  } exp_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  exp_t sbq [$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sel_out(input logic sat, output logic v, output logic f, output logic t_v,
                         output logic [1:0] s, output logic [1:0] t, output logic [11:0] h,
                         output logic [11:0] m, output logic [7:0] c);
    if (sat) begin
      v = vo4; f = fo4; t_v = tv4; s = so4; t = to4; h = {8'd0, ho4}; m = {8'd0, ms4}; c = mc4;
    end else begin
      v = vo;  f = fo;  t_v = tv;  s = so;  t = to;  h = ho; m = ms; c = mc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, f, t_v;
    logic [1:0] s, t;
    logic [11:0] h, m;
    logic [7:0] c;
    exp_t e;

    //        ld  q  vld fst s  h    sat eh  et em  ec
    tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0,  0, 0,  0};
    tbl[1]  = '{0, 0, 1, 1, 0, 0,  0, 2,  1, 2,  0};
    tbl[2]  = '{0, 0, 1, 0, 0, 0,  0, 2,  1, 2,  0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,  0, 2,  0, 0,  0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0,  0, 2,  1, 2,  0};
    tbl[5]  = '{0, 0, 1, 1, 1, 0,  0, 0,  0, 0,  0};
    tbl[6]  = '{0, 0, 1, 0, 2, 0,  0, 0,  0, 0,  0};
    tbl[7]  = '{1, 2, 0, 0, 0, 0,  0, 0,  0, 0,  0};
    tbl[8]  = '{0, 0, 1, 1, 3, 5,  0, 4,  2, 4,  0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0,  0, 4,  0, 0,  0};
    tbl[10] = '{0, 0, 1, 1, 1, 2,  0, 1,  2, 1,  0};
    tbl[11] = '{0, 0, 1, 0, 0, 5,  0, 4,  1, 4,  1};
    tbl[12] = '{0, 0, 1, 0, 1, 0,  0, 4,  1, 4,  1};
    tbl[13] = '{0, 0, 1, 0, 1, 0,  0, 3,  3, 4,  1};
    tbl[14] = '{0, 0, 1, 1, 1, 15, 1, 14, 2, 14, 0};
    tbl[15] = '{0, 0, 1, 0, 0, 15, 1, 15, 1, 15, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 0,  1, 15, 0, 0,  0};

    reset = 1'b1; q_load = 0; q_in = 0; valid_in = 0; first_in = 0; s_in = 0; h_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_h_out", ho, 0);
    chk("rst_max", ms, 0);
    chk("rst_valid", vo, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      q_load = tbl[i].ld; q_in = tbl[i].q; valid_in = tbl[i].vld;
      first_in = tbl[i].first; s_in = tbl[i].s; h_in = tbl[i].h;
      if (tbl[i].vld)
        sbq.push_back('{tbl[i].sat, tbl[i].first, tbl[i].s, tbl[i].eh, tbl[i].et, tbl[i].em, tbl[i].ec});
      @(posedge clk); #1;
      sel_out(tbl[i].sat, v, f, t_v, s, t, h, m, c);
      if (!tbl[i].vld) begin
        chk($sformatf("v%0d_bubble_valid", i), {31'd0, v}, 0);
        chk($sformatf("v%0d_bubble_tvalid", i), {31'd0, t_v}, 0);
        chk($sformatf("v%0d_hold_h", i), h, tbl[i].eh);
        $display("vec %0d: bubble h_out=%0d", i, h);
      end else if (sbq.size() == 0) begin
        chk($sformatf("v%0d_sb_empty", i), 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_valid", i), {31'd0, v}, 1);
        chk($sformatf("v%0d_tvalid", i), {31'd0, t_v}, 1);
        chk($sformatf("v%0d_first", i), {31'd0, f}, {31'd0, e.first});
        chk($sformatf("v%0d_s_out", i), {30'd0, s}, {30'd0, e.s});
        chk($sformatf("v%0d_h_out", i), h, e.eh);
        chk($sformatf("v%0d_t_out", i), {30'd0, t}, {30'd0, e.et});
        chk($sformatf("v%0d_max", i), m, e.em);
        chk($sformatf("v%0d_col", i), c, e.ec);
        $display("vec %0d: h_out=%0d t_out=%0d max=%0d@%0d", i, h, t, m, c);
      end
    end
    chk("sb_drained", sbq.size(), 0);

    // Mid-stream reset: q=T, beat T/h_in=7 gives H=6 via UP; then reset clears everything.
    @(negedge clk);
    q_load = 1; q_in = 2'd3; valid_in = 0;
    @(negedge clk);
    q_load = 0; valid_in = 1; first_in = 1; s_in = 2'd3; h_in = 12'd7;
    @(posedge clk); #1;
    chk("pre_rst_h", ho, 6);
    chk("pre_rst_t", {30'd0, to}, 2);
    $display("mid-stream beat: h_out=%0d t_out=%0d", ho, to);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_h", ho, 0);
    chk("mid_rst_max", ms, 0);
    chk("mid_rst_valid", {31'd0, vo}, 0);
    chk("mid_rst_t", {30'd0, to}, 0);
    chk("mid_rst_s", {30'd0, so}, 0);
    $display("mid-stream reset: h_out=%0d max=%0d valid=%0d", ho, ms, vo);
    @(negedge clk);
    reset = 1'b0; first_in = 1; s_in = 2'd0; h_in = 12'd0; valid_in = 1;
    @(posedge clk); #1;
    // Query base returned to A, so base A now matches.
    chk("post_rst_h", ho, 2);
    chk("post_rst_t", {30'd0, to}, 1);
    chk("post_rst_max", ms, 2);
    $display("post-reset beat: h_out=%0d t_out=%0d max=%0d", ho, to, ms);
    @(negedge clk); valid_in = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
